// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// stage and the MEM stage of a 5-stage MIPS pipeline. Each access is
// sequenced as grant -> issue -> wait -> capture -> ready pulse. Data
// accesses have priority. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants made while fetch was waiting.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   if_req_i, if_addr_i       fetch request (held until if_ready_o)
//   if_rdata_o, if_ready_o    fetched word, one-cycle completion pulse
//   dm_read_i, dm_write_i     data request (held until dm_ready_o)
//   dm_addr_i, dm_wdata_i     data address / write data
//   dm_rdata_o, dm_ready_o    read word, one-cycle completion pulse
//   mem_en_o, mem_we_o        memory strobe (one cycle per access), write enable
//   mem_addr_o, mem_wdata_o   memory address / write data, valid with mem_en_o
//   mem_rdata_i               memory read data, MEM_LAT cycles after mem_en_o
//   pipe_stall_o              some requester is still unserved
//   busy_o                    arbiter is not idle
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch address/wdata
// ISSUE | mem_en_o high for the latched access
// WAIT  | count down the read latency, capture mem_rdata_i on the last count
// DONE  | ready pulse to the granted requester

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              pipe_stall_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          starve_q, starve_d;
    logic                gnt_dm_q, gnt_dm_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                dm_ready_q, dm_ready_d;

    logic dm_req;
    logic force_if;

    assign dm_req   = dm_read_i | dm_write_i;
    assign force_if = if_req_i && (starve_q == STARVE_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        gnt_dm_d    = gnt_dm_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req_i || dm_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (dm_req && !force_if) begin
                        gnt_dm_d    = 1'b1;
                        // read+write together performs the write only
                        mem_we_d    = dm_write_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        if (!if_req_i) begin
                            starve_d = 4'd0;
                        end else if (starve_q != STARVE_C) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        gnt_dm_d   = 1'b0;
                        mem_addr_d = if_addr_i;
                        starve_d   = 4'd0;
                    end
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    // only the data port can write
                    state_d    = DONE;
                    dm_ready_d = 1'b1;
                end else begin
                    cnt_d   = LAT_C;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // count of 1 here is the cycle the counter reaches 0,
                // i.e. MEM_LAT cycles after the issue cycle
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (gnt_dm_q) begin
                        dm_rdata_d = mem_rdata_i;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                        if_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            gnt_dm_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            gnt_dm_q    <= gnt_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign if_rdata_o   = if_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign dm_rdata_o   = dm_rdata_q;
    assign dm_ready_o   = dm_ready_q;
    assign busy_o       = (state_q != IDLE);
    assign pipe_stall_o = (if_req_i & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
// Stimulus pushes expected memory strobes and ready pulses into queues;
// a negedge monitor pops and compares whenever the DUT presents one.

module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_read_i;
    logic        dm_write_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        pipe_stall_o;
    logic        busy_o;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .dm_read_i(dm_read_i), .dm_write_i(dm_write_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .pipe_stall_o(pipe_stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    typedef struct {
        int          c;
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
    } mem_exp_t;

    typedef struct {
        int          c;
        logic        chk_d;
        logic [31:0] d;
    } rdy_exp_t;

    mem_exp_t q_mem[$];
    rdy_exp_t q_if[$];
    rdy_exp_t q_dm[$];
    mem_exp_t me;
    rdy_exp_t re;

    task automatic push_mem(input int c, input logic [31:0] a, input logic we, input logic [31:0] d);
        mem_exp_t e;
        e.c = c; e.a = a; e.we = we; e.d = d;
        q_mem.push_back(e);
    endtask

    task automatic push_rdy(input logic is_dm, input int c, input logic chk_d, input logic [31:0] d);
        rdy_exp_t e;
        e.c = c; e.chk_d = chk_d; e.d = d;
        if (is_dm) q_dm.push_back(e);
        else q_if.push_back(e);
    endtask

    // Memory model: word = addr + 0x2001FFCA, driven only in the cycle
    // MEM_LAT after the strobe; junk in every other cycle.
    logic        pend = 1'b0;
    int          rd_cyc;
    logic [31:0] rd_addr;
    always @(negedge clk_i) begin
        if (pend && cyc == rd_cyc) begin
            mem_rdata_i = rd_addr + 32'h2001_FFCA;
            pend = 1'b0;
        end else begin
            mem_rdata_i = 32'hBAD0_0000 ^ 32'(cyc);
        end
        if (mem_en_o && !mem_we_o) begin
            pend    = 1'b1;
            rd_cyc  = cyc + LAT;
            rd_addr = mem_addr_o;
        end
    end

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (mem_en_o) begin
            if (q_mem.size() == 0) chk("mem_en_spurious", 1, 0);
            else begin
                me = q_mem.pop_front();
                chk("mem_en_cycle", 64'(cyc), 64'(me.c));
                chk("mem_addr", mem_addr_o, me.a);
                chk("mem_we", mem_we_o, me.we);
                if (me.we) chk("mem_wdata", mem_wdata_o, me.d);
            end
        end
        if (if_ready_o) begin
            if (q_if.size() == 0) chk("if_ready_spurious", 1, 0);
            else begin
                re = q_if.pop_front();
                chk("if_ready_cycle", 64'(cyc), 64'(re.c));
                if (re.chk_d) chk("if_rdata", if_rdata_o, re.d);
            end
        end
        if (dm_ready_o) begin
            if (q_dm.size() == 0) chk("dm_ready_spurious", 1, 0);
            else begin
                re = q_dm.pop_front();
                chk("dm_ready_cycle", 64'(cyc), 64'(re.c));
                if (re.chk_d) chk("dm_rdata", dm_rdata_o, re.d);
            end
        end
    end

    // advance to the negedge of cycle t
    task automatic at(input int t);
        do @(negedge clk_i); while (cyc < t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0;

    initial begin
        reset_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
        dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;

        // reset values
        at(2);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        chk("rst_dm_ready", dm_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", pipe_stall_o, 0);
        reset_i = 1'b0;

        // 1: single fetch, stall and busy windows
        t0 = cyc + 2;
        for (int k = 0; k <= 5; k++) begin
            at(t0 + k);
            if (k == 0) begin
                if_req_i = 1'b1; if_addr_i = 32'h40;
                push_mem(t0 + 1, 32'h40, 1'b0, 32'h0);
                push_rdy(1'b0, t0 + 4, 1'b1, 32'h2002_000A);
            end
            #1;
            chk("t1_stall", pipe_stall_o, (k <= 3) ? 1 : 0);
            chk("t1_busy", busy_o, (k >= 1 && k <= 4) ? 1 : 0);
            if (k == 4) if_req_i = 1'b0;
        end

        // 2: simultaneous fetch and data read, data first
        t0 = cyc + 3;
        at(t0);
        if_req_i = 1'b1; if_addr_i = 32'h80;
        dm_read_i = 1'b1; dm_addr_i = 32'h100;
        push_mem(t0 + 1, 32'h100, 1'b0, 32'h0);
        push_rdy(1'b1, t0 + 4, 1'b1, 32'h2002_00CA);
        push_mem(t0 + 6, 32'h80, 1'b0, 32'h0);
        push_rdy(1'b0, t0 + 9, 1'b1, 32'h2002_004A);
        at(t0 + 4); dm_read_i = 1'b0;
        at(t0 + 9); if_req_i = 1'b0;

        // 3: starvation, order D D F D D F
        t0 = cyc + 3;
        at(t0);
        if_req_i = 1'b1; if_addr_i = 32'h80;
        dm_read_i = 1'b1; dm_addr_i = 32'h200;
        push_mem(t0 + 1,  32'h200, 1'b0, 32'h0);
        push_rdy(1'b1, t0 + 4,  1'b1, 32'h2002_01CA);
        push_mem(t0 + 6,  32'h204, 1'b0, 32'h0);
        push_rdy(1'b1, t0 + 9,  1'b1, 32'h2002_01CE);
        push_mem(t0 + 11, 32'h80,  1'b0, 32'h0);
        push_rdy(1'b0, t0 + 14, 1'b1, 32'h2002_004A);
        push_mem(t0 + 16, 32'h208, 1'b0, 32'h0);
        push_rdy(1'b1, t0 + 19, 1'b1, 32'h2002_01D2);
        push_mem(t0 + 21, 32'h20C, 1'b0, 32'h0);
        push_rdy(1'b1, t0 + 24, 1'b1, 32'h2002_01D6);
        push_mem(t0 + 26, 32'h80,  1'b0, 32'h0);
        push_rdy(1'b0, t0 + 29, 1'b1, 32'h2002_004A);
        at(t0 + 4);  dm_addr_i = 32'h204;
        at(t0 + 9);  dm_addr_i = 32'h208;
        at(t0 + 19); dm_addr_i = 32'h20C;
        at(t0 + 24); dm_addr_i = 32'h210;
        at(t0 + 26); dm_read_i = 1'b0;
        at(t0 + 29); if_req_i = 1'b0;

        // 4: data write
        t0 = cyc + 3;
        at(t0);
        dm_write_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEAD_BEEF;
        push_mem(t0 + 1, 32'h10, 1'b1, 32'hDEAD_BEEF);
        push_rdy(1'b1, t0 + 2, 1'b0, 32'h0);
        at(t0 + 2); dm_write_i = 1'b0;

        // 6: read and write together perform only the write
        t0 = cyc + 3;
        at(t0);
        dm_read_i = 1'b1; dm_write_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h5;
        push_mem(t0 + 1, 32'h20, 1'b1, 32'h5);
        push_rdy(1'b1, t0 + 2, 1'b0, 32'h0);
        at(t0 + 2); dm_read_i = 1'b0; dm_write_i = 1'b0;

        // 5: reset aborts an in-flight read
        t0 = cyc + 3;
        at(t0);
        dm_read_i = 1'b1; dm_addr_i = 32'h300;
        push_mem(t0 + 1, 32'h300, 1'b0, 32'h0);
        at(t0 + 2); reset_i = 1'b1; dm_read_i = 1'b0;
        at(t0 + 3);
        chk("t5_busy", busy_o, 0);
        chk("t5_dm_ready", dm_ready_o, 0);
        chk("t5_dm_rdata", dm_rdata_o, 0);
        chk("t5_mem_addr", mem_addr_o, 0);
        reset_i = 1'b0;
        at(t0 + 4);
        if_req_i = 1'b1; if_addr_i = 32'h44;
        push_mem(t0 + 5, 32'h44, 1'b0, 32'h0);
        push_rdy(1'b0, t0 + 8, 1'b1, 32'h2002_000E);
        at(t0 + 8); if_req_i = 1'b0;

        at(cyc + 6);
        chk("left_mem", 64'(q_mem.size()), 0);
        chk("left_if", 64'(q_if.size()), 0);
        chk("left_dm", 64'(q_dm.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
